// File: rtl/branch_pred_pkg.sv
// Shared definitions for the branch resolve queue and the one-bit predictor table.
package branch_pred_pkg;

  localparam int unsigned DEPTH_DEF = 4;
  localparam int unsigned IDX_W_DEF = 1;
  localparam int unsigned CNT_W_DEF = 16;

  // Direction encoding shared with the predictor table
  localparam logic TAKEN     = 1'b1;
  localparam logic NOT_TAKEN = 1'b0;

  // Entry bit layout: {index, pred}, pred in bit 0
  localparam int unsigned ENTRY_PRED_LSB = 0;
  localparam int unsigned ENTRY_IDX_LSB  = 1;

  // Entry payload at the default index width
  typedef struct packed {
    logic [IDX_W_DEF-1:0] index;
    logic                 pred;
  } entry_t;

endpackage

// File: rtl/branch_sat_counter.sv
// Saturating up-counter with enable; holds at all-ones instead of wrapping.
module branch_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Increment when enabled unless already saturated
  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order queue of in-flight branches; pops on resolution, drives predictor
// updates and flushes everything younger on a mispredict.
module branch_resolve_queue
  import branch_pred_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned IDX_W = IDX_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic [IDX_W-1:0]         push_index,
  input  logic                     push_pred,
  input  logic                     res_valid,
  output logic                     res_ready,
  input  logic                     res_taken,
  output logic                     upd_valid,
  output logic [IDX_W-1:0]         upd_index,
  output logic                     upd_taken,
  output logic                     mispredict,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [CNT_W-1:0]         branch_cnt,
  output logic [CNT_W-1:0]         mispred_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;
  localparam int unsigned ENT_W = IDX_W + 1;

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [OCC_W-1:0] count_q, count_d;

  logic             upd_valid_q, upd_valid_d;
  logic [IDX_W-1:0] upd_index_q, upd_index_d;
  logic             upd_taken_q, upd_taken_d;
  logic             mispred_q, mispred_d;

  logic [ENT_W-1:0] head_ent;
  logic [ENT_W-1:0] wr_ent;
  logic [IDX_W-1:0] head_idx;
  logic             head_pred;
  logic             push_fire;
  logic             res_fire;
  logic             mis_fire;
  logic             wr_en;

  // Handshakes depend on registered count only
  assign push_ready = (count_q != OCC_W'(DEPTH));
  assign res_ready  = (count_q != '0);

  // Head decode, handshake qualification and new-entry packing
  always_comb begin
    head_ent  = mem_q[head_q];
    head_idx  = head_ent[ENTRY_IDX_LSB +: IDX_W];
    head_pred = head_ent[ENTRY_PRED_LSB];
    push_fire = push_valid && push_ready;
    res_fire  = res_valid && res_ready;
    mis_fire  = res_fire && (head_pred != res_taken);
    // A push alongside a mispredict is wrong-path and dropped
    wr_en     = push_fire && !mis_fire;
    wr_ent                              = '0;
    wr_ent[ENTRY_IDX_LSB +: IDX_W]      = push_index;
    wr_ent[ENTRY_PRED_LSB]              = push_pred;
  end

  // Pointer/count next state and registered update strobe
  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    upd_valid_d = 1'b0;
    upd_index_d = '0;
    upd_taken_d = 1'b0;
    mispred_d   = 1'b0;

    if (mis_fire) begin
      head_d  = tail_q;
      count_d = '0;
    end else begin
      if (res_fire) begin
        head_d = head_q + PTR_W'(1);
      end
      if (push_fire) begin
        tail_d = tail_q + PTR_W'(1);
      end
      count_d = count_q + OCC_W'(push_fire) - OCC_W'(res_fire);
    end

    if (res_fire) begin
      upd_valid_d = 1'b1;
      upd_index_d = head_idx;
      upd_taken_d = res_taken;
      mispred_d   = mis_fire;
    end
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      upd_valid_q <= 1'b0;
      upd_index_q <= '0;
      upd_taken_q <= 1'b0;
      mispred_q   <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      upd_valid_q <= upd_valid_d;
      upd_index_q <= upd_index_d;
      upd_taken_q <= upd_taken_d;
      mispred_q   <= mispred_d;
    end
  end

  // Entry storage; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[tail_q] <= wr_ent;
    end
  end

  branch_sat_counter #(.CNT_W(CNT_W)) u_branch_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (res_fire),
    .cnt_o (branch_cnt)
  );

  branch_sat_counter #(.CNT_W(CNT_W)) u_mispred_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (mis_fire),
    .cnt_o (mispred_cnt)
  );

  assign upd_valid  = upd_valid_q;
  assign upd_index  = upd_index_q;
  assign upd_taken  = upd_taken_q;
  assign mispredict = mispred_q;
  assign occupancy  = count_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Scoreboard bench: driver models the queue as an ordered list and queues the
// expected post-edge response; a monitor compares one cycle later.
module tb_branch_resolve_queue;

  localparam int DEPTH = 4;
  localparam int IDX_W = 3;
  localparam int CNT_W = 3;
  localparam int OCC_W = 3;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             push_valid = 1'b0;
  logic             push_ready;
  logic [IDX_W-1:0] push_index = '0;
  logic             push_pred = 1'b0;
  logic             res_valid = 1'b0;
  logic             res_ready;
  logic             res_taken = 1'b0;
  logic             upd_valid;
  logic [IDX_W-1:0] upd_index;
  logic             upd_taken;
  logic             mispredict;
  logic [OCC_W-1:0] occupancy;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  branch_resolve_queue #(.DEPTH(DEPTH), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_valid  (push_valid),
    .push_ready  (push_ready),
    .push_index  (push_index),
    .push_pred   (push_pred),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_taken   (res_taken),
    .upd_valid   (upd_valid),
    .upd_index   (upd_index),
    .upd_taken   (upd_taken),
    .mispredict  (mispredict),
    .occupancy   (occupancy),
    .branch_cnt  (branch_cnt),
    .mispred_cnt (mispred_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IDX_W-1:0] idx;
    bit               pred;
  } ent_t;

  typedef struct {
    bit               upd;
    logic [IDX_W-1:0] idx;
    bit               tk;
    bit               mis;
    int               occ;
    int               bc;
    int               mc;
  } exp_t;

  ent_t mq[$];
  exp_t sb[$];
  int   m_bc = 0;
  int   m_mc = 0;
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d @%0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit head_pred();
    return (mq.size() > 0) ? mq[0].pred : 1'b0;
  endfunction

  // Apply one cycle of stimulus and queue the response expected after the edge
  task automatic step(input bit pv, input logic [IDX_W-1:0] idx, input bit pd,
                      input bit rv, input bit tk);
    bit   pr, rr, pf, rf;
    exp_t e;
    ent_t n;
    @(negedge clk);
    push_valid = pv; push_index = idx; push_pred = pd;
    res_valid  = rv; res_taken  = tk;
    pr = (mq.size() < DEPTH);
    rr = (mq.size() > 0);
    chk("push_ready", int'(push_ready), int'(pr));
    chk("res_ready", int'(res_ready), int'(rr));
    pf = pv && pr;
    rf = rv && rr;
    n.idx = idx; n.pred = pd;
    e = '{upd: 1'b0, idx: '0, tk: 1'b0, mis: 1'b0, occ: 0, bc: 0, mc: 0};
    if (rf) begin
      e.upd = 1'b1;
      e.idx = mq[0].idx;
      e.tk  = tk;
      e.mis = (mq[0].pred != tk);
      if (m_bc < SAT) m_bc++;
      if (e.mis) begin
        if (m_mc < SAT) m_mc++;
        mq.delete();
      end else begin
        void'(mq.pop_front());
        if (pf) mq.push_back(n);
      end
    end else if (pf) begin
      mq.push_back(n);
    end
    e.occ = mq.size();
    e.bc  = m_bc;
    e.mc  = m_mc;
    sb.push_back(e);
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset between edges; outputs must clear without a clock
  task automatic do_reset();
    @(negedge clk);
    #2;
    push_valid = 1'b0; res_valid = 1'b0;
    rst_n = 1'b0;
    sb.delete();
    mq.delete();
    m_bc = 0; m_mc = 0;
    #1;
    chk("rst upd_valid", int'(upd_valid), 0);
    chk("rst mispredict", int'(mispredict), 0);
    chk("rst push_ready", int'(push_ready), 1);
    chk("rst res_ready", int'(res_ready), 0);
    chk("rst occupancy", int'(occupancy), 0);
    chk("rst branch_cnt", int'(branch_cnt), 0);
    chk("rst mispred_cnt", int'(mispred_cnt), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: compare DUT outputs against the scoreboard just after each edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("upd_valid", int'(upd_valid), int'(e.upd));
        if (e.upd) begin
          chk("upd_index", int'(upd_index), int'(e.idx));
          chk("upd_taken", int'(upd_taken), int'(e.tk));
        end
        chk("mispredict", int'(mispredict), int'(e.mis));
        chk("occupancy", int'(occupancy), e.occ);
        chk("branch_cnt", int'(branch_cnt), e.bc);
        chk("mispred_cnt", int'(mispred_cnt), e.mc);
      end else if (rst_n) begin
        chk("idle upd_valid", int'(upd_valid), 0);
        chk("idle mispredict", int'(mispredict), 0);
      end
    end
  end

  initial begin
    bit               pv, rv, tk;
    logic [IDX_W-1:0] ri;
    do_reset();

    // In-order correct resolves
    step(1'b1, 3'd0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    idle(); idle();

    // Mispredict flush with a simultaneous wrong-path push
    do_reset();
    step(1'b1, 3'd5, 1'b1, 1'b0, 1'b0);
    step(1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'd3, 1'b1, 1'b0, 1'b0);
    step(1'b1, 3'd6, 1'b1, 1'b1, 1'b0);
    step(1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
    idle();

    // Full boundary then wrap-around with paired push/resolve
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b1, IDX_W'(i + 1), i[0], 1'b0, 1'b0);
    step(1'b1, 3'd7, 1'b0, 1'b1, head_pred());
    for (int i = 0; i < 2 * DEPTH; i++) step(1'b1, IDX_W'(i), ~i[1], 1'b1, head_pred());
    while (mq.size() > 0) step(1'b0, '0, 1'b0, 1'b1, head_pred());
    idle();

    // Empty resolve, then push+resolve at occupancy 1
    do_reset();
    step(1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 3'd4, 1'b1, 1'b0, 1'b0);
    step(1'b1, 3'd5, 1'b0, 1'b1, 1'b1);
    step(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    idle();

    // Saturation: 10 mispredicts
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, IDX_W'(i), 1'b1, 1'b0, 1'b0);
      step(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    end
    idle(); idle();

    // Random traffic with a reset in the middle right after a resolve
    do_reset();
    for (int i = 0; i < 400; i++) begin
      pv = ($urandom_range(0, 3) != 0);
      rv = ($urandom_range(0, 2) != 0);
      ri = IDX_W'($urandom);
      tk = ($urandom_range(0, 5) == 0) ? ~head_pred() : head_pred();
      if (i == 200) begin
        step(1'b1, ri, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b1);
        do_reset();
      end else begin
        step(pv, ri, 1'b0 ^ ($urandom_range(0, 1) == 1), rv, tk);
      end
    end
    idle();
    @(posedge clk);
    #3;
    chk("scoreboard drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
